fifo_rr_drain_arbiter: RTL and testbench
========================================

# fifo_rr_drain_arbiter

Round-robin drain controller that shares one downstream valid/ready sink between `n_fifos` upstream flip-flop FIFOs. It watches each FIFO's `empty` flag, issues `pop` to exactly one granted FIFO at a time, and registers the popped head word into a single output stage. A grant is held for bursts of up to `max_burst` words. The block sits between per-requester FIFO instances and a shared consumer such as a bus master or serializer.

## Interface
- `n_fifos`, 4, number of upstream FIFOs (≥2)
- `width`, 8, data word width
- `max_burst`, 4, maximum consecutive pops per grant (≥1)

- `clk`  input  1  clock; all state updates on posedge
- `rst_n`  input  1  asynchronous active-low reset
- `fifo_empty`  input  n_fifos  per-FIFO empty flag
- `fifo_read_data`  input  n_fifos × width  per-FIFO head word, valid whenever that FIFO is not empty
- `fifo_pop`  output  n_fifos  one-hot-or-zero pop strobes
- `out_valid`  output  1  output register holds a word
- `out_ready`  input  1  downstream accepts the word this cycle
- `out_data`  output  width  registered word

## Operation
- States:
  - `IDLE`: no grant.
  - `BURST`: `grant` index held, with burst counter `cnt`.
- `can_load = ~out_valid | out_ready`.
- In `BURST`: `fifo_pop[grant] = ~fifo_empty[grant] & can_load`, all other pops 0.
- In `IDLE`: all pops 0.
- On a pop:
  - `out_data <= fifo_read_data[grant]`
  - `out_valid <= 1`
  - `cnt <= cnt + 1`
- If `out_ready & out_valid` and no pop: `out_valid <= 0`.
- Next-grant search: rotating priority starting at `last_grant + 1` mod `n_fifos`, wrapping past `n_fifos-1` to 0. `last_grant` itself is checked last.
- `IDLE` → `BURST`: when any `fifo_empty` bit is 0. Load `grant` from the search, `cnt <= 0`.
- `BURST` exit condition: either of
  - a pop with `cnt == max_burst-1`, or
  - `fifo_empty[grant] == 1`.
- On exit:
  - `last_grant <= grant`.
  - Run the search with the updated `last_grant`. If a non-empty FIFO is found, stay in `BURST` with the new grant and `cnt <= 0` (no bubble). Otherwise go to `IDLE`.
- `out_ready` low with `out_valid` high: no pop. State, `cnt`, `out_data` and `out_valid` all hold.
- Widths:
  - `cnt` is `$clog2(max_burst)` bits, minimum 1.
  - `grant` and `last_grant` are `$clog2(n_fifos)` bits.
  - All increments wrap modulo the parameter value, never the power of two.

## Timing
- Reset values, asynchronous:
  - `state = IDLE`, `out_valid = 0`, `out_data = 0`, `cnt = 0`
  - `last_grant = n_fifos-1`, so the first grant goes to FIFO 0.
  - `fifo_pop = 0` for the whole time `rst_n` is low.
- Arbitration latency: one cycle from the first non-empty flag seen in `IDLE` to the first pop.
- Pop → `out_valid`/`out_data` visible after the next posedge (1-cycle latency).
- Throughput: 1 word/cycle sustained while `out_ready = 1`, including across grant switches.
- A granted FIFO that empties before `max_burst` costs one idle cycle: its empty flag is seen, then the grant moves.
- `fifo_pop` is combinational from state and inputs. The consuming FIFO samples it on the same posedge.
- Reset mid-burst: outputs drop immediately. The word in flight is discarded. Upstream FIFO contents are untouched.

## Structure
- Package `fifo_arb_pkg`: state enum typedef `arb_state_t {IDLE, BURST}`.
- Sub-module `rr_next_index`: purely combinational.
  - Inputs: request vector and `last_grant`.
  - Outputs: `found` and `index`.
  - Instantiated once.
- Output register and FSM live in the top module.

## Test plan
All scenarios use `n_fifos=4`, `width=8`, `max_burst=4`, real FIFO instances upstream, and a downstream scoreboard.
- Reset: hold `rst_n` low with all FIFOs non-empty → `fifo_pop=0`, `out_valid=0`. After release, the first pop goes to FIFO 0 on cycle 2.
- Single requester: FIFO 1 holds 0x10..0x15, `out_ready=1` → out sequence 0x10,0x11,0x12,0x13,0x14,0x15. The re-grant to FIFO 1 at burst end has no bubble. After draining: one empty-observed cycle, then `IDLE`.
- Full contention: each FIFO holds 8 words, `out_ready=1` → four words from 0, then 1, 2, 3, then 0, 1, 2, 3 again. 32 consecutive valid cycles after the first.
- Backpressure: drop `out_ready` for 3 cycles mid-burst → `out_data` and `out_valid` stable, `fifo_pop=0`, burst resumes with `cnt` unchanged. No loss or duplication.
- Wrap-around: `last_grant=3`, FIFOs 0 and 2 non-empty → next grant is FIFO 0, then FIFO 2.
- Reset mid-operation: assert `rst_n` low while `out_valid=1` → `out_valid` falls without waiting for a clock edge. After release, arbitration restarts at FIFO 0. Remaining FIFO data drains in order.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types for the round-robin FIFO drain arbiter
package fifo_arb_pkg;
    typedef enum logic {IDLE, BURST} arb_state_t;
endpackage

// File: rtl/fifo_rr_drain_arbiter_rr_next_index.sv
// rr_next_index: rotating-priority search for the next requester
// Ports:
//   req_i    request vector, one bit per requester
//   last_i   previously granted index; searched last, starting at last_i+1
//   found_o  at least one request is set
//   index_o  first requesting index in rotating order (0 when none)
module rr_next_index #(
    parameter int n  = 4,
    parameter int gw = 2
) (
    input  logic [n-1:0]  req_i,
    input  logic [gw-1:0] last_i,
    output logic          found_o,
    output logic [gw-1:0] index_o
);
    logic hit;
    always_comb begin
        hit = 1'b0;
        index_o = '0;
        for (int i = 1; i <= n; i++) begin
            if (!hit && req_i[(int'(last_i) + i) % n]) begin
                hit = 1'b1;
                index_o = gw'((int'(last_i) + i) % n);
            end
        end
    end
    assign found_o = hit;
endmodule

// File: rtl/fifo_rr_drain_arbiter.sv
// fifo_rr_drain_arbiter: round-robin burst drain of n_fifos FIFOs into one registered valid/ready output
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   fifo_empty      per-FIFO empty flags
//   fifo_read_data  per-FIFO head words, FIFO i at [i*width +: width]
//   fifo_pop        one-hot-or-zero pop strobes, combinational
//   out_valid       output register holds a word
//   out_ready       downstream accepts the word this cycle
//   out_data        registered output word
module fifo_rr_drain_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int n_fifos   = 4,
    parameter int width     = 8,
    parameter int max_burst = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [n_fifos-1:0]         fifo_empty,
    input  logic [n_fifos*width-1:0]   fifo_read_data,
    output logic [n_fifos-1:0]         fifo_pop,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [width-1:0]           out_data
);
    localparam int gw = $clog2(n_fifos);
    localparam int cw = max_burst > 1 ? $clog2(max_burst) : 1;

    arb_state_t       state_q, state_d;
    logic [gw-1:0]    grant_q, grant_d, last_q, last_d, next_idx;
    logic [cw-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [width-1:0] out_data_q, out_data_d;
    logic             pop, done, found;

    assign pop  = state_q == BURST && !fifo_empty[grant_q] && (!out_valid_q || out_ready);
    // A burst ends on its last allowed pop or once the granted FIFO is seen empty
    assign done = state_q == BURST && (fifo_empty[grant_q] || (pop && cnt_q == cw'(max_burst - 1)));
    assign fifo_pop  = pop ? n_fifos'(1) << grant_q : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // On a burst exit the current grant becomes last_grant, so search from it directly
    rr_next_index #(.n(n_fifos), .gw(gw)) u_rr (
        .req_i   (~fifo_empty),
        .last_i  (state_q == BURST ? grant_q : last_q),
        .found_o (found),
        .index_o (next_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d = last_q;
        cnt_d = pop ? cnt_q + 1'b1 : cnt_q;
        out_valid_d = pop || (out_valid_q && !out_ready);
        out_data_d = pop ? fifo_read_data[grant_q*width +: width] : out_data_q;
        if (state_q == IDLE || done) begin
            last_d = done ? grant_q : last_q;
            state_d = found ? BURST : IDLE;
            grant_d = found ? next_idx : grant_q;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q <= gw'(n_fifos - 1);
            cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
        end
    end
endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// tb_fifo_rr_drain_arbiter: randomized drain bench with queue FIFOs and a burst-level order model
module tb_fifo_rr_drain_arbiter;
    localparam int N = 4, W = 8, MB = 4;
    typedef logic [W-1:0] word_q_t[$];

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] fifo_empty, fifo_pop;
    logic [N*W-1:0] fifo_read_data;
    logic out_valid, out_ready, out_data_unused;
    logic [W-1:0] out_data;

    word_q_t q[N];
    word_q_t exp_q, rx;
    int compared = 0, mismatched = 0;
    int last_m = N - 1;
    int cyc = 0, first_acc = -1, last_acc = -1;

    fifo_rr_drain_arbiter #(.n_fifos(N), .width(W), .max_burst(MB)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
        .fifo_pop(fifo_pop), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = q[i].size() == 0;
            fifo_read_data[i*W +: W] = q[i].size() == 0 ? '0 : q[i][0];
        end
    endtask

    // Expected output order: visit FIFOs in rotating order after the last one served,
    // taking up to MB words from each non-empty FIFO per visit
    task automatic build_exp();
        int rem[N], pos[N], g, idx, t;
        exp_q.delete();
        rx.delete();
        first_acc = -1;
        last_acc = -1;
        for (int i = 0; i < N; i++) begin
            rem[i] = q[i].size();
            pos[i] = 0;
        end
        g = last_m;
        forever begin
            idx = -1;
            for (int k = 1; k <= N && idx < 0; k++)
                if (rem[(g + k) % N] > 0) idx = (g + k) % N;
            if (idx < 0) break;
            t = rem[idx] < MB ? rem[idx] : MB;
            for (int j = 0; j < t; j++) exp_q.push_back(q[idx][pos[idx] + j]);
            pos[idx] += t;
            rem[idx] -= t;
            g = idx;
        end
        last_m = g;
    endtask

    // mode: 0/1 forces out_ready, 2 randomizes it
    task automatic cycle(input int mode);
        logic [N-1:0] pm;
        logic acc, hold;
        logic [W-1:0] d;
        @(negedge clk);
        out_ready = mode == 2 ? ($urandom_range(0, 3) != 0) : mode[0];
        #1;
        chk("pop_onehot0", {31'b0, $onehot0(fifo_pop)}, 1);
        pm = fifo_pop;
        acc = out_valid && out_ready;
        hold = out_valid && !out_ready;
        d = out_data;
        if (hold) chk("bp_pop", {28'b0, fifo_pop}, 0);
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            rx.push_back(d);
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        for (int i = 0; i < N; i++) if (pm[i]) void'(q[i].pop_front());
        refresh();
        if (hold) begin
            chk("bp_valid", {31'b0, out_valid}, 1);
            chk("bp_data", {24'b0, out_data}, {24'b0, d});
        end
    endtask

    task automatic compare_rx(input string tag);
        chk({tag, "_count"}, rx.size(), exp_q.size());
        for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
            chk({tag, "_word"}, {24'b0, rx[i]}, {24'b0, exp_q[i]});
    endtask

    task automatic drain(input string tag, input int mode);
        int budget = 600;
        while (rx.size() < exp_q.size() && budget > 0) begin
            cycle(mode);
            budget--;
        end
        if (budget == 0) chk({tag, "_timeout"}, 1, 0);
        repeat (4) cycle(1);
        compare_rx(tag);
        chk({tag, "_idle_valid"}, {31'b0, out_valid}, 0);
    endtask

    task automatic fill(input int i, input int n, input int base);
        for (int j = 0; j < n; j++) q[i].push_back(base < 0 ? W'($urandom) : W'(base + j));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_m = N - 1;
    endtask

    initial begin
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) fill(i, 3, 8'h40 + 8'h10 * i);
        refresh();
        repeat (3) begin
            @(negedge clk);
            chk("rst_pop", {28'b0, fifo_pop}, 0);
            chk("rst_valid", {31'b0, out_valid}, 0);
            chk("rst_data", {24'b0, out_data}, 0);
        end
        rst_n = 1'b1;
        #1 chk("release_pop", {28'b0, fifo_pop}, 0);
        build_exp();
        @(posedge clk);
        #1 chk("first_pop", {28'b0, fifo_pop}, 4'b0001);
        drain("reset_start", 1);

        fill(1, 6, 8'h10);
        refresh();
        build_exp();
        drain("single", 1);
        chk("single_gapless", last_acc - first_acc + 1, 6);

        pulse_reset();
        for (int i = 0; i < N; i++) fill(i, 8, -1);
        refresh();
        build_exp();
        drain("contention", 1);
        chk("contention_gapless", last_acc - first_acc + 1, 32);
        chk("contention_first", {24'b0, rx[0]}, {24'b0, exp_q[0]});

        pulse_reset();
        fill(0, 2, 8'hA0);
        fill(2, 2, 8'hC0);
        refresh();
        build_exp();
        drain("wrap", 1);
        chk("wrap_order0", {24'b0, rx[0]}, 8'hA0);
        chk("wrap_order2", {24'b0, rx[2]}, 8'hC0);

        fill(0, 8, 8'h60);
        refresh();
        build_exp();
        repeat (3) cycle(1);
        repeat (3) cycle(0);
        drain("backpressure", 1);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) fill(i, $urandom_range(0, 9), -1);
            refresh();
            build_exp();
            drain("random", 2);
        end

        for (int i = 0; i < N; i++) fill(i, $urandom_range(5, 9), -1);
        refresh();
        build_exp();
        begin
            int budget = 200;
            while ((rx.size() < 5 || !out_valid) && budget > 0) begin
                cycle(2);
                budget--;
            end
            if (budget == 0) chk("midreset_timeout", 1, 0);
        end
        chk("midreset_prefix_valid", {31'b0, out_valid}, 1);
        for (int i = 0; i < rx.size(); i++) chk("midreset_prefix", {24'b0, rx[i]}, {24'b0, exp_q[i]});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_valid", {31'b0, out_valid}, 0);
        chk("midreset_pop", {28'b0, fifo_pop}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_m = N - 1;
        build_exp();
        drain("after_reset", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
